pe_tile_core: RTL and testbench

Single-PE tile of the CGRA fabric. Operands are chosen from twenty 16-bit routing tracks (4 sides × 5 tracks) and combined in a 16-bit ALU. The result, or a pass-through track, drives output track S3/T1. All behaviour is set by a tile-addressed configuration bus that is sampled every cycle. There is no separate write strobe.

---
 rtl/pe_tile_core_pkg.sv | 54 +++++
 rtl/pe_tile_core_alu.sv | 29 ++
 rtl/pe_tile_core.sv | 176 +++++++++++++++++
 tb/tb_pe_tile_core.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_tile_core_pkg.sv
// Shared constants and config layout for the single-PE CGRA tile.
package pe_tile_core_pkg;

    localparam int unsigned NUM_TRACKS = 20;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_SHL  = 4'd3;
    localparam logic [3:0] OP_SHR  = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_PASS = 4'd8;
    localparam logic [3:0] OP_MAXU = 4'd9;
    localparam logic [3:0] OP_MINU = 4'd10;

    localparam logic [7:0] FEAT_PE  = 8'h00;
    localparam logic [7:0] FEAT_CBA = 8'h01;
    localparam logic [7:0] FEAT_CBB = 8'h02;
    localparam logic [7:0] FEAT_SB  = 8'h03;

    localparam logic [7:0] REG_PE_CFG  = 8'hFF;
    localparam logic [7:0] REG_CONST_A = 8'hF0;
    localparam logic [7:0] REG_CONST_B = 8'hF1;
    localparam logic [7:0] REG_SEL     = 8'h00;

    localparam int unsigned PE_OP_LSB     = 0;
    localparam int unsigned PE_A_CONST    = 16;
    localparam int unsigned PE_B_CONST    = 17;
    localparam int unsigned PE_OUT_REG    = 20;
    localparam int unsigned PE_EN_SEL_LSB = 21;

    typedef struct packed {
        logic [3:0] op;
        logic       a_const;
        logic       b_const;
        logic       out_reg;
        logic [2:0] en_sel;
    } pe_cfg_t;

    localparam pe_cfg_t PE_CFG_RESET = '0;

    function automatic pe_cfg_t to_pe_cfg(input logic [31:0] data);
        pe_cfg_t c;
        c.op      = data[PE_OP_LSB +: 4];
        c.a_const = data[PE_A_CONST];
        c.b_const = data[PE_B_CONST];
        c.out_reg = data[PE_OUT_REG];
        c.en_sel  = data[PE_EN_SEL_LSB +: 3];
        return c;
    endfunction

endpackage

// File: rtl/pe_tile_core_alu.sv
// Combinational 16-bit unsigned ALU of the PE; all results wrap modulo 2^16.
import pe_tile_core_pkg::*;

module pe_alu (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [3:0]  op,
    output logic [15:0] result
);

    always_comb begin
        result = '0;
        unique case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_MUL:  result = a * b;
            OP_SHL:  result = a << b[3:0];
            OP_SHR:  result = a >> b[3:0];
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_PASS: result = a;
            OP_MAXU: result = (a > b) ? a : b;
            OP_MINU: result = (a < b) ? a : b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/pe_tile_core.sv
// CGRA tile: config registers, connection boxes, PE with optional output
// register, and the switch-box mux driving track S3/T1.
import pe_tile_core_pkg::*;

module pe_tile_core (
    input  logic        clk_in,
    input  logic        reset,
    input  logic [15:0] tile_id,
    input  logic [31:0] config_addr,
    input  logic [31:0] config_data,
    input  logic [15:0] in_BUS16_S0_T0,
    input  logic [15:0] in_BUS16_S0_T1,
    input  logic [15:0] in_BUS16_S0_T2,
    input  logic [15:0] in_BUS16_S0_T3,
    input  logic [15:0] in_BUS16_S0_T4,
    input  logic [15:0] in_BUS16_S1_T0,
    input  logic [15:0] in_BUS16_S1_T1,
    input  logic [15:0] in_BUS16_S1_T2,
    input  logic [15:0] in_BUS16_S1_T3,
    input  logic [15:0] in_BUS16_S1_T4,
    input  logic [15:0] in_BUS16_S2_T0,
    input  logic [15:0] in_BUS16_S2_T1,
    input  logic [15:0] in_BUS16_S2_T2,
    input  logic [15:0] in_BUS16_S2_T3,
    input  logic [15:0] in_BUS16_S2_T4,
    input  logic [15:0] in_BUS16_S3_T0,
    input  logic [15:0] in_BUS16_S3_T1,
    input  logic [15:0] in_BUS16_S3_T2,
    input  logic [15:0] in_BUS16_S3_T3,
    input  logic [15:0] in_BUS16_S3_T4,
    input  logic        in_BUS1_S1_T0,
    input  logic        in_BUS1_S1_T1,
    input  logic        in_BUS1_S1_T2,
    input  logic        in_BUS1_S1_T3,
    input  logic        in_BUS1_S1_T4,
    output logic [15:0] out_BUS16_S3_T1
);

    logic [15:0] track [NUM_TRACKS];
    logic [4:0]  en_bus;

    assign track = '{
        in_BUS16_S0_T0, in_BUS16_S0_T1, in_BUS16_S0_T2,
        in_BUS16_S0_T3, in_BUS16_S0_T4,
        in_BUS16_S1_T0, in_BUS16_S1_T1, in_BUS16_S1_T2,
        in_BUS16_S1_T3, in_BUS16_S1_T4,
        in_BUS16_S2_T0, in_BUS16_S2_T1, in_BUS16_S2_T2,
        in_BUS16_S2_T3, in_BUS16_S2_T4,
        in_BUS16_S3_T0, in_BUS16_S3_T1, in_BUS16_S3_T2,
        in_BUS16_S3_T3, in_BUS16_S3_T4
    };

    assign en_bus = {
        in_BUS1_S1_T4, in_BUS1_S1_T3, in_BUS1_S1_T2,
        in_BUS1_S1_T1, in_BUS1_S1_T0
    };

    pe_cfg_t     pe_cfg;
    logic [15:0] const_a;
    logic [15:0] const_b;
    logic [4:0]  cb_a_sel;
    logic [4:0]  cb_b_sel;
    logic [2:0]  sb_sel;

    logic       cfg_hit;
    logic [7:0] cfg_feat;
    logic [7:0] cfg_reg;
    logic       wr_pe_cfg;
    logic       wr_const_a;
    logic       wr_const_b;
    logic       wr_cb_a;
    logic       wr_cb_b;
    logic       wr_sb;
    logic       unused_cfg_bits;

    assign cfg_hit  = (config_addr[15:0] == tile_id);
    assign cfg_feat = config_addr[23:16];
    assign cfg_reg  = config_addr[31:24];

    assign wr_pe_cfg  = cfg_feat == FEAT_PE  && cfg_reg == REG_PE_CFG;
    assign wr_const_a = cfg_feat == FEAT_PE  && cfg_reg == REG_CONST_A;
    assign wr_const_b = cfg_feat == FEAT_PE  && cfg_reg == REG_CONST_B;
    assign wr_cb_a    = cfg_feat == FEAT_CBA && cfg_reg == REG_SEL;
    assign wr_cb_b    = cfg_feat == FEAT_CBB && cfg_reg == REG_SEL;
    assign wr_sb      = cfg_feat == FEAT_SB  && cfg_reg == REG_SEL;

    assign unused_cfg_bits = ^{config_data[31:24], config_data[19:18]};

    // Unmapped feature/register pairs fall through to the empty default.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            pe_cfg   <= PE_CFG_RESET;
            const_a  <= '0;
            const_b  <= '0;
            cb_a_sel <= '0;
            cb_b_sel <= '0;
            sb_sel   <= '0;
        end else if (cfg_hit) begin
            unique case (1'b1)
                wr_pe_cfg:  pe_cfg   <= to_pe_cfg(config_data);
                wr_const_a: const_a  <= config_data[15:0];
                wr_const_b: const_b  <= config_data[15:0];
                wr_cb_a:    cb_a_sel <= config_data[4:0];
                wr_cb_b:    cb_b_sel <= config_data[4:0];
                wr_sb:      sb_sel   <= config_data[2:0];
                default: ;
            endcase
        end
    end

    logic [15:0] cb_a;
    logic [15:0] cb_b;

    // Selections past the last track leave the operand at zero.
    always_comb begin
        cb_a = '0;
        cb_b = '0;
        for (int i = 0; i < NUM_TRACKS; i++) begin
            if (cb_a_sel == 5'(i)) cb_a = track[i];
            if (cb_b_sel == 5'(i)) cb_b = track[i];
        end
    end

    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_res;

    assign alu_a = pe_cfg.a_const ? const_a : cb_a;
    assign alu_b = pe_cfg.b_const ? const_b : cb_b;

    pe_alu u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .op     (pe_cfg.op),
        .result (alu_res)
    );

    logic        reg_en;
    logic [15:0] out_q;
    logic [15:0] pe_out;

    always_comb begin
        reg_en = 1'b1;
        unique case (pe_cfg.en_sel)
            3'd0:    reg_en = en_bus[0];
            3'd1:    reg_en = en_bus[1];
            3'd2:    reg_en = en_bus[2];
            3'd3:    reg_en = en_bus[3];
            3'd4:    reg_en = en_bus[4];
            default: reg_en = 1'b1;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            out_q <= '0;
        end else if (reg_en) begin
            out_q <= alu_res;
        end
    end

    assign pe_out = pe_cfg.out_reg ? out_q : alu_res;

    always_comb begin
        out_BUS16_S3_T1 = '0;
        unique case (sb_sel)
            3'd0:    out_BUS16_S3_T1 = pe_out;
            3'd1:    out_BUS16_S3_T1 = track[1];
            3'd2:    out_BUS16_S3_T1 = track[6];
            3'd3:    out_BUS16_S3_T1 = track[11];
            3'd4:    out_BUS16_S3_T1 = track[16];
            default: out_BUS16_S3_T1 = '0;
        endcase
    end

endmodule

// File: tb/tb_pe_tile_core.sv
// Randomized bench for pe_tile_core against a behavioural tile model.
module tb_pe_tile_core;

    localparam logic [15:0] TILE = 16'h0015;

    logic        clk_in = 1'b0;
    logic        reset;
    logic [15:0] tile_id = TILE;
    logic [31:0] config_addr;
    logic [31:0] config_data;
    logic [15:0] trk [20];
    logic [4:0]  en1;
    logic [15:0] dout;

    int checks = 0;
    int passes = 0;

    always #5 clk_in = ~clk_in;

    pe_tile_core dut (
        .clk_in          (clk_in),
        .reset           (reset),
        .tile_id         (tile_id),
        .config_addr     (config_addr),
        .config_data     (config_data),
        .in_BUS16_S0_T0  (trk[0]),
        .in_BUS16_S0_T1  (trk[1]),
        .in_BUS16_S0_T2  (trk[2]),
        .in_BUS16_S0_T3  (trk[3]),
        .in_BUS16_S0_T4  (trk[4]),
        .in_BUS16_S1_T0  (trk[5]),
        .in_BUS16_S1_T1  (trk[6]),
        .in_BUS16_S1_T2  (trk[7]),
        .in_BUS16_S1_T3  (trk[8]),
        .in_BUS16_S1_T4  (trk[9]),
        .in_BUS16_S2_T0  (trk[10]),
        .in_BUS16_S2_T1  (trk[11]),
        .in_BUS16_S2_T2  (trk[12]),
        .in_BUS16_S2_T3  (trk[13]),
        .in_BUS16_S2_T4  (trk[14]),
        .in_BUS16_S3_T0  (trk[15]),
        .in_BUS16_S3_T1  (trk[16]),
        .in_BUS16_S3_T2  (trk[17]),
        .in_BUS16_S3_T3  (trk[18]),
        .in_BUS16_S3_T4  (trk[19]),
        .in_BUS1_S1_T0   (en1[0]),
        .in_BUS1_S1_T1   (en1[1]),
        .in_BUS1_S1_T2   (en1[2]),
        .in_BUS1_S1_T3   (en1[3]),
        .in_BUS1_S1_T4   (en1[4]),
        .out_BUS16_S3_T1 (dout)
    );

    // Behavioural model state: the tile's configuration and output register.
    int m_op, m_ac, m_bc, m_or, m_en, m_ca, m_cb, m_sa, m_sb, m_ssb, m_reg;

    function automatic int ref_alu(int op, int a, int b);
        longint p;
        case (op)
            0: return (a + b) % 65536;
            1: return (a - b + 65536) % 65536;
            2: begin p = longint'(a) * longint'(b); return int'(p % 65536); end
            3: return (a * (2 ** (b % 16))) % 65536;
            4: return a / (2 ** (b % 16));
            5: return a & b;
            6: return a | b;
            7: return a ^ b;
            8: return a;
            9: return (a > b) ? a : b;
            10: return (a < b) ? a : b;
            default: return 0;
        endcase
    endfunction

    function automatic int ref_track(int sel);
        return (sel < 20) ? int'(trk[sel]) : 0;
    endfunction

    function automatic int ref_result();
        int a, b;
        a = m_ac ? m_ca : ref_track(m_sa);
        b = m_bc ? m_cb : ref_track(m_sb);
        return ref_alu(m_op, a, b);
    endfunction

    function automatic int ref_out();
        int pe;
        pe = m_or ? m_reg : ref_result();
        if (m_ssb == 0) return pe;
        if (m_ssb <= 4) return int'(trk[5 * (m_ssb - 1) + 1]);
        return 0;
    endfunction

    function automatic bit ref_en();
        return (m_en < 5) ? bit'(en1[m_en]) : 1'b1;
    endfunction

    task automatic model_reset();
        m_op = 0; m_ac = 0; m_bc = 0; m_or = 0; m_en = 0;
        m_ca = 0; m_cb = 0; m_sa = 0; m_sb = 0; m_ssb = 0; m_reg = 0;
    endtask

    task automatic model_write(logic [31:0] addr, logic [31:0] data);
        int f, r;
        if (addr[15:0] != TILE) return;
        f = int'(addr[23:16]);
        r = int'(addr[31:24]);
        if (f == 0 && r == 255) begin
            m_op = int'(data[3:0]);
            m_ac = int'(data[16]);
            m_bc = int'(data[17]);
            m_or = int'(data[20]);
            m_en = int'(data[23:21]);
        end
        else if (f == 0 && r == 240) m_ca = int'(data[15:0]);
        else if (f == 0 && r == 241) m_cb = int'(data[15:0]);
        else if (f == 1 && r == 0) m_sa = int'(data[4:0]);
        else if (f == 2 && r == 0) m_sb = int'(data[4:0]);
        else if (f == 3 && r == 0) m_ssb = int'(data[2:0]);
    endtask

    // One rising edge: the register sees the old config, then the write lands.
    task automatic tick();
        int  res;
        bit  en;
        res = ref_result();
        en  = ref_en();
        @(posedge clk_in);
        if (!reset) begin
            if (en) m_reg = res;
            model_write(config_addr, config_data);
        end
        #1;
    endtask

    task automatic wr(logic [15:0] t, logic [7:0] f, logic [7:0] r, logic [31:0] d);
        config_addr = {r, f, t};
        config_data = d;
        tick();
        config_addr = 32'h0000_FFFF;
        config_data = '0;
    endtask

    task automatic set_all(logic [15:0] v);
        for (int i = 0; i < 20; i++) trk[i] = v;
    endtask

    task automatic randomize_tracks();
        for (int i = 0; i < 20; i++) trk[i] = 16'($urandom);
    endtask

    task automatic test_reset();
        set_all(16'd490);
        en1 = '0;
        config_addr = {8'hFF, 8'h00, TILE};
        config_data = 32'h1;
        reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if (dout !== 16'd980) $display("FAIL reset_hold got %0d exp 980", dout);
        else passes++;
        tick();
        @(negedge clk_in);
        reset = 1'b0;
        config_addr = 32'h0000_FFFF;
        #1;
        checks++;
        if (dout !== 16'd980) $display("FAIL reset_default got %0d exp 980", dout);
        else passes++;
        tick();
        checks++;
        if (dout !== 16'd980) $display("FAIL reset_write_lost got %0d exp 980", dout);
        else passes++;
    endtask

    task automatic test_nonmatch();
        wr(16'h0000, 8'h00, 8'hFF, 32'h1);
        wr(16'h0014, 8'h00, 8'hFF, 32'h1);
        checks++;
        if (dout !== 16'd980) $display("FAIL nonmatch got %0d exp 980", dout);
        else passes++;
    endtask

    task automatic test_mul_const();
        trk[7] = 16'd1000;
        wr(TILE, 8'h00, 8'hFF, 32'h0002_0002);
        wr(TILE, 8'h00, 8'hF1, 32'd2);
        config_addr = {8'h00, 8'h01, TILE};
        config_data = 32'd7;
        #1;
        checks++;
        if (dout !== 16'(ref_out())) $display("FAIL mul_old_cfg got %0d exp %0d", dout, ref_out());
        else passes++;
        tick();
        config_addr = 32'h0000_FFFF;
        #1;
        checks++;
        if (dout !== 16'd2000) $display("FAIL mul_const got %0d exp 2000", dout);
        else passes++;
        for (int i = 0; i < 4; i++) begin
            trk[7] = 16'($urandom);
            #1;
            checks++;
            if (dout !== 16'(ref_out())) $display("FAIL mul_rand got %0d exp %0d", dout, ref_out());
            else passes++;
        end
    endtask

    task automatic test_out_reg();
        int held;
        wr(TILE, 8'h01, 8'h00, 32'd0);
        wr(TILE, 8'h00, 8'hFF, 32'h0030_0000);
        for (int i = 0; i < 16; i++) begin
            trk[0] = 16'($urandom);
            en1 = 5'($urandom);
            #1;
            checks++;
            if (dout !== 16'(ref_out())) $display("FAIL oreg_pre[%0d] got %0d exp %0d", i, dout, ref_out());
            else passes++;
            tick();
            checks++;
            if (dout !== 16'(ref_out())) $display("FAIL oreg_post[%0d] got %0d exp %0d", i, dout, ref_out());
            else passes++;
        end
        en1[1] = 1'b1;
        trk[0] = 16'd100;
        tick();
        en1[1] = 1'b0;
        trk[0] = 16'd7;
        tick();
        tick();
        held = 200;
        checks++;
        if (dout !== 16'(held)) $display("FAIL oreg_hold got %0d exp %0d", dout, held);
        else passes++;
        en1[1] = 1'b1;
        tick();
        checks++;
        if (dout !== 16'd14) $display("FAIL oreg_load got %0d exp 14", dout);
        else passes++;
        set_all(16'd490);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if (dout !== 16'd980) $display("FAIL oreg_reset got %0d exp 980", dout);
        else passes++;
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (dout !== 16'd980) $display("FAIL oreg_after_reset got %0d exp 980", dout);
        else passes++;
    endtask

    task automatic test_sb();
        randomize_tracks();
        wr(TILE, 8'h03, 8'h00, 32'd4);
        checks++;
        if (dout !== trk[16]) $display("FAIL sb_s3 got %h exp %h", dout, trk[16]);
        else passes++;
        for (int s = 1; s <= 3; s++) begin
            wr(TILE, 8'h03, 8'h00, 32'(s));
            checks++;
            if (dout !== 16'(ref_out())) $display("FAIL sb_pass%0d got %h exp %h", s, dout, ref_out());
            else passes++;
        end
        wr(TILE, 8'h03, 8'h00, 32'd6);
        checks++;
        if (dout !== 16'd0) $display("FAIL sb_zero got %h exp 0", dout);
        else passes++;
        wr(TILE, 8'h03, 8'h00, 32'd0);
    endtask

    task automatic test_edges();
        wr(TILE, 8'h00, 8'hFF, 32'h0003_0000);
        wr(TILE, 8'h00, 8'hF0, 32'h0000_FFFF);
        wr(TILE, 8'h00, 8'hF1, 32'h0000_0001);
        checks++;
        if (dout !== 16'd0) $display("FAIL add_wrap got %h exp 0", dout);
        else passes++;
        wr(TILE, 8'h00, 8'hFF, 32'h0003_0003);
        wr(TILE, 8'h00, 8'hF0, 32'h0000_0001);
        wr(TILE, 8'h00, 8'hF1, 32'h0000_0013);
        checks++;
        if (dout !== 16'd8) $display("FAIL shl_mask got %h exp 8", dout);
        else passes++;
        randomize_tracks();
        wr(TILE, 8'h00, 8'hFF, 32'h0001_0000);
        wr(TILE, 8'h00, 8'hF0, 32'h0000_0005);
        wr(TILE, 8'h02, 8'h00, 32'd25);
        checks++;
        if (dout !== 16'd5) $display("FAIL cb_sel25 got %h exp 5", dout);
        else passes++;
    endtask

    task automatic test_random();
        logic [15:0] t;
        logic [7:0]  f, r;
        logic [7:0]  regs [5];
        regs[0] = 8'hFF; regs[1] = 8'hF0; regs[2] = 8'hF1;
        regs[3] = 8'h00; regs[4] = 8'h5A;
        for (int i = 0; i < 60; i++) begin
            t = ($urandom_range(0, 3) != 0) ? TILE : 16'($urandom);
            f = 8'($urandom_range(0, 4));
            r = regs[$urandom_range(0, 4)];
            randomize_tracks();
            en1 = 5'($urandom);
            config_addr = {r, f, t};
            config_data = $urandom;
            if (f == 8'h03 && $urandom_range(0, 1) == 1) config_data[2:0] = 3'd0;
            #1;
            checks++;
            if (dout !== 16'(ref_out())) $display("FAIL rand_pre[%0d] got %h exp %h", i, dout, ref_out());
            else passes++;
            tick();
            config_addr = 32'h0000_FFFF;
            #1;
            checks++;
            if (dout !== 16'(ref_out())) $display("FAIL rand_post[%0d] got %h exp %h", i, dout, ref_out());
            else passes++;
        end
    endtask

    initial begin
        reset = 1'b0;
        config_addr = 32'h0000_FFFF;
        config_data = '0;
        en1 = '0;
        set_all(16'd0);
        model_reset();
        test_reset();
        test_nonmatch();
        test_mul_const();
        test_out_reg();
        test_sb();
        test_edges();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
